clkgen_prog: RTL and testbench

CLKGEN_PROG -- requirements
Module: clkgen_prog

---
 rtl/clkgen_prog.sv | 121 ++++++++++++
 tb/tb_clkgen_prog.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_prog.sv
// -----------------------------------------------------------------------------
// clkgen_prog
//
// A bank of NCH programmable clock dividers, all running from one input clock.
// Each channel counts active clkin cycles up to its limit. When the count
// reaches the limit it wraps to zero, toggles its square-wave output and
// raises a one-cycle tick. The half-period is therefore lim+1 active cycles.
//
// Ports
//   clkin     in   1       clock; every register updates on its rising edge
//   rst       in   1       synchronous active-high reset
//   clken     in   1       global enable shared by all channels
//   ch_en     in   NCH     per-channel enable
//   sync      in   1       clears every counter and output (phase alignment)
//   wr_en     in   1       limit write strobe
//   wr_ch     in   WW      channel index for the write
//                          (out-of-range indices are ignored)
//   wr_limit  in   CW      new half-period limit
//   clkout    out  NCH     divided square waves (registered)
//   tick      out  NCH     one-cycle pulse on every half-period wrap
//                          (registered)
// -----------------------------------------------------------------------------
module clkgen_prog #(
  parameter int NCH       = 4,
  parameter int CW        = 32,
  parameter int SYS_FREQ  = 100000000,
  parameter int DEF_FREQ  = 1000,
  parameter int DEF_LIMIT = SYS_FREQ / 2 / DEF_FREQ - 1
) (
  input  logic                                     clkin,
  input  logic                                     rst,
  input  logic                                     clken,
  input  logic [NCH-1:0]                           ch_en,
  input  logic                                     sync,
  input  logic                                     wr_en,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] wr_ch,
  input  logic [CW-1:0]                            wr_limit,
  output logic [NCH-1:0]                           clkout,
  output logic [NCH-1:0]                           tick
);

  localparam int WW = (NCH > 1) ? $clog2(NCH) : 1;

  // Reset value of every limit.
  localparam logic [CW-1:0] LIM_RST = CW'(DEF_LIMIT);

  logic [NCH-1:0] clk_vec;
  logic [NCH-1:0] tick_vec;

  assign clkout = clk_vec;
  assign tick   = tick_vec;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    // Power-up values match the reset values.
    logic [CW-1:0] cnt_reg  = '0;
    logic [CW-1:0] lim_reg  = LIM_RST;
    logic          clk_reg  = 1'b0;
    logic          tick_reg = 1'b0;

    logic [CW-1:0] cnt_next;
    logic [CW-1:0] lim_next;
    logic          clk_next;
    logic          tick_next;

    logic          active;
    logic          wr_hit;

    assign active = clken & ch_en[gi];

    // The write is decoded by exact match, so an index of NCH or larger
    // selects no channel and the write is dropped.
    assign wr_hit = wr_en && (wr_ch == WW'(gi));

    always_comb begin
      cnt_next  = cnt_reg;
      lim_next  = lim_reg;
      clk_next  = clk_reg;
      tick_next = 1'b0;

      // A limit write never touches the counter or output. The compare below
      // reads lim_reg, so the old limit still governs the write cycle.
      if (wr_hit) begin
        lim_next = wr_limit;
      end

      if (sync) begin
        cnt_next = '0;
        clk_next = 1'b0;
      end else if (active) begin
        // Using >= rather than == means a limit lowered below the current
        // count forces a wrap on the next active cycle. Without it the
        // counter would run all the way round the CW-bit range.
        if (cnt_reg >= lim_reg) begin
          cnt_next  = '0;
          clk_next  = ~clk_reg;
          tick_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
    end

    always_ff @(posedge clkin) begin
      if (rst) begin
        cnt_reg  <= '0;
        lim_reg  <= LIM_RST;
        clk_reg  <= 1'b0;
        tick_reg <= 1'b0;
      end else begin
        cnt_reg  <= cnt_next;
        lim_reg  <= lim_next;
        clk_reg  <= clk_next;
        tick_reg <= tick_next;
      end
    end

    assign clk_vec[gi]  = clk_reg;
    assign tick_vec[gi] = tick_reg;
  end

endmodule

// File: tb/tb_clkgen_prog.sv
// -----------------------------------------------------------------------------
// tb_clkgen_prog
//
// Drives clkgen_prog with NCH=3, CW=8 and DEF_LIMIT=4 (SYS_FREQ=100,
// DEF_FREQ=10). A table of per-cycle input records holds the hand-computed
// clkout/tick values expected after each rising edge. A hand-written
// sequence then measures the spacing of tick pulses.
// -----------------------------------------------------------------------------
module tb_clkgen_prog;

  localparam int NCH = 3;
  localparam int CW  = 8;

  logic           clkin;
  logic           rst;
  logic           clken;
  logic [NCH-1:0] ch_en;
  logic           sync;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [CW-1:0]  wr_limit;
  logic [NCH-1:0] clkout;
  logic [NCH-1:0] tick;

  int n_checks = 0;
  int n_fail   = 0;

  clkgen_prog #(
    .NCH      (NCH),
    .CW       (CW),
    .SYS_FREQ (100),
    .DEF_FREQ (10)
  ) dut (
    .clkin    (clkin),
    .rst      (rst),
    .clken    (clken),
    .ch_en    (ch_en),
    .sync     (sync),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_limit (wr_limit),
    .clkout   (clkout),
    .tick     (tick)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  typedef struct {
    string      tag;
    logic       rst;
    logic       clken;
    logic [2:0] ch_en;
    logic       sync;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_limit;
    logic [2:0] exp_clk;
    logic [2:0] exp_tick;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string tag, input logic r, input logic ce,
                              input logic [2:0] en, input logic sy, input logic we,
                              input logic [1:0] wc, input logic [7:0] wl,
                              input logic [2:0] ec, input logic [2:0] et);
    vec_t v;
    v.tag = tag; v.rst = r; v.clken = ce; v.ch_en = en; v.sync = sy;
    v.wr_en = we; v.wr_ch = wc; v.wr_limit = wl; v.exp_clk = ec; v.exp_tick = et;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end else begin
      $display("ok   %s: %0b", name, act);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; clken = v.clken; ch_en = v.ch_en; sync = v.sync;
    wr_en = v.wr_en; wr_ch = v.wr_ch; wr_limit = v.wr_limit;
  endtask

  initial begin
    int t1;
    int t2;

    // rst clken en sync wr ch lim | clkout tick
    // Reset together with a write and a sync: the write must be lost.
    add("rst_wr_sync", 1, 1, 3'b111, 1, 1, 0, 5, 3'b000, 3'b000);
    add("rst2",        1, 0, 3'b000, 0, 0, 0, 0, 3'b000, 3'b000);
    // Load ch0=3, ch1=0 while disabled; ch2 keeps the default limit 4.
    add("wr_ch0",      0, 0, 3'b000, 0, 1, 0, 3, 3'b000, 3'b000);
    add("wr_ch1",      0, 0, 3'b000, 0, 1, 1, 0, 3'b000, 3'b000);
    // Free run: ch0 every 4 cycles, ch1 every cycle, ch2 every 5.
    add("run1",  0, 1, 3'b111, 0, 0, 0, 0, 3'b010, 3'b010);
    add("run2",  0, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b010);
    add("run3",  0, 1, 3'b111, 0, 0, 0, 0, 3'b010, 3'b010);
    add("run4",  0, 1, 3'b111, 0, 0, 0, 0, 3'b001, 3'b011);
    add("run5",  0, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b110);
    add("run6",  0, 1, 3'b111, 0, 0, 0, 0, 3'b101, 3'b010);
    add("run7",  0, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b010);
    add("run8",  0, 1, 3'b111, 0, 0, 0, 0, 3'b100, 3'b011);
    add("run9",  0, 1, 3'b111, 0, 0, 0, 0, 3'b110, 3'b010);
    add("run10", 0, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b110);
    // ch0 frozen at count 2 for 5 cycles, then resumes and wraps after 2.
    add("frz1",  0, 1, 3'b110, 0, 0, 0, 0, 3'b010, 3'b010);
    add("frz2",  0, 1, 3'b110, 0, 0, 0, 0, 3'b000, 3'b010);
    add("frz3",  0, 1, 3'b110, 0, 0, 0, 0, 3'b010, 3'b010);
    add("frz4",  0, 1, 3'b110, 0, 0, 0, 0, 3'b000, 3'b010);
    add("frz5",  0, 1, 3'b110, 0, 0, 0, 0, 3'b110, 3'b110);
    add("res1",  0, 1, 3'b111, 0, 0, 0, 0, 3'b100, 3'b010);
    add("res2",  0, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b011);
    add("s1",    0, 1, 3'b111, 0, 0, 0, 0, 3'b101, 3'b010);
    add("s2",    0, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b010);
    add("s3",    0, 1, 3'b111, 0, 0, 0, 0, 3'b001, 3'b110);
    // ch0 at count 3 = old limit; writing 9 this cycle must not stop the wrap.
    add("wr_old_lim", 0, 1, 3'b111, 0, 1, 0, 9, 3'b010, 3'b011);
    for (int i = 1; i <= 7; i++)
      add($sformatf("cnt9_%0d", i), 0, 1, 3'b001, 0, 0, 0, 0, 3'b010, 3'b000);
    // Count is 7; lower the limit to 2 while idle -> wrap on next active cycle.
    add("lower_lim", 0, 0, 3'b001, 0, 1, 0, 2, 3'b010, 3'b000);
    add("low1",  0, 1, 3'b001, 0, 0, 0, 0, 3'b011, 3'b001);
    add("low2",  0, 1, 3'b001, 0, 0, 0, 0, 3'b011, 3'b000);
    add("low3",  0, 1, 3'b001, 0, 0, 0, 0, 3'b011, 3'b000);
    add("low4",  0, 1, 3'b001, 0, 0, 0, 0, 3'b010, 3'b001);
    // Out-of-range write index 3 with limit 0: nothing may change.
    add("wr_oor",  0, 1, 3'b001, 0, 1, 3, 0, 3'b010, 3'b000);
    add("oor2",    0, 1, 3'b001, 0, 0, 0, 0, 3'b010, 3'b000);
    add("oor3",    0, 1, 3'b001, 0, 0, 0, 0, 3'b011, 3'b001);
    // Sync with a simultaneous write of ch2=2: ch0 and ch2 then run aligned.
    add("sync_wr", 0, 1, 3'b111, 1, 1, 2, 2, 3'b000, 3'b000);
    add("al1",   0, 1, 3'b111, 0, 0, 0, 0, 3'b010, 3'b010);
    add("al2",   0, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b010);
    add("al3",   0, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b111);
    add("al4",   0, 1, 3'b111, 0, 0, 0, 0, 3'b101, 3'b010);
    add("al5",   0, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b010);
    add("al6",   0, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b111);
    add("al7",   0, 1, 3'b111, 0, 0, 0, 0, 3'b010, 3'b010);
    add("al8",   0, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b010);
    add("al9",   0, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b111);
    // Sync still clears with clken low.
    add("sync_noen", 0, 0, 3'b111, 1, 0, 0, 0, 3'b000, 3'b000);
    add("al10",  0, 1, 3'b111, 0, 0, 0, 0, 3'b010, 3'b010);
    // Mid-period reset with write+sync: all limits back to 4.
    add("rst_mid", 1, 1, 3'b111, 1, 1, 0, 5, 3'b000, 3'b000);
    add("dl1",   0, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
    add("dl2",   0, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
    add("dl3",   0, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
    add("dl4",   0, 1, 3'b111, 0, 0, 0, 0, 3'b000, 3'b000);
    add("dl5",   0, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b111);
    add("dl6",   0, 1, 3'b111, 0, 0, 0, 0, 3'b111, 3'b000);

    // Power-up state, before any clock edge.
    rst = 1'b1; clken = 1'b0; ch_en = '0; sync = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_limit = '0;
    #1;
    check("powerup_clkout", 32'(clkout), 32'h0);
    check("powerup_tick",   32'(tick),   32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      check({vecs[i].tag, "_clkout"}, 32'(clkout), 32'(vecs[i].exp_clk));
      check({vecs[i].tag, "_tick"},   32'(tick),   32'(vecs[i].exp_tick));
    end

    // Hand sequence: ch1 limit 6 -> ticks every 7 active cycles.
    rst = 1'b0; clken = 1'b0; ch_en = 3'b000; sync = 1'b0;
    wr_en = 1'b1; wr_ch = 2'd1; wr_limit = 8'd6;
    step();
    wr_en = 1'b0; sync = 1'b1;
    step();
    check("hs_sync_clkout", 32'(clkout), 32'h0);
    sync = 1'b0; clken = 1'b1; ch_en = 3'b010;
    t1 = 0;
    t2 = 0;
    for (int cyc = 1; cyc <= 40 && t2 == 0; cyc++) begin
      step();
      if (tick[1]) begin
        if (t1 == 0) begin
          t1 = cyc;
          check("hs_clkout_after_tick1", 32'(clkout), 32'b010);
        end else begin
          t2 = cyc;
        end
      end
    end
    check("hs_first_tick_cycle",  32'(t1), 32'd7);
    check("hs_second_tick_cycle", 32'(t2), 32'd14);
    check("hs_clkout_end",        32'(clkout), 32'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
